// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA copy engine.
package dma_pkg;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 192;
    localparam int RSVD_ADDR = 191;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RD,
        S_RD_WAIT,
        S_WR,
        S_FIN
    } dma_state_t;

endpackage

// File: rtl/dma_copy_engine_if.sv
// Control and memory bus of the DMA copy engine.
// Defining DMA_CHECKSUM_EN adds the running checksum output csum.
interface dma_copy_engine_if;
    import dma_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [ADDR_W-1:0] len;
    logic              busy;
    logic              done;
    logic              err;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_full;
`ifdef DMA_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    modport master (
        input  start, src_addr, dst_addr, len, mem_rdata, mem_full,
        output busy, done, err, mem_wr, mem_addr, mem_wdata
`ifdef DMA_CHECKSUM_EN
        , output csum
`endif
    );

    modport slave (
        output start, src_addr, dst_addr, len, mem_rdata, mem_full,
        input  busy, done, err, mem_wr, mem_addr, mem_wdata
`ifdef DMA_CHECKSUM_EN
        , input csum
`endif
    );

endinterface

// File: rtl/dma_range_check.sv
// Combinational range check of a latched transfer; sums are one bit wider so they cannot wrap.
module dma_range_check
    import dma_pkg::*;
(
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
    output logic              ok,
    output logic              zero_len,
    output logic              violation
);

    logic [ADDR_W:0] src_end;
    logic [ADDR_W:0] dst_end;

    assign src_end  = {1'b0, src} + {1'b0, len};
    assign dst_end  = {1'b0, dst} + {1'b0, len};
    assign zero_len = (len == '0);

    // The destination limit stops one word short so the reserved status word is never written.
    assign violation = !zero_len &&
                       ((src_end > (ADDR_W+1)'(MEM_DEPTH)) ||
                        (dst_end > (ADDR_W+1)'(RSVD_ADDR)));
    assign ok        = !zero_len && !violation;

endmodule

// File: rtl/dma_copy_engine.sv
// Single-channel memory-to-memory DMA copy engine (read-then-write per word).
// Optional feature macro: DMA_CHECKSUM_EN adds csum, the modular sum of words written.
module dma_copy_engine
    import dma_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    dma_copy_engine_if.master  bus
);

    dma_state_t        state;
    dma_state_t        state_next;
    logic [ADDR_W-1:0] cur_src;
    logic [ADDR_W-1:0] cur_dst;
    logic [ADDR_W-1:0] remaining;
    logic [DATA_W-1:0] buffer;
    logic              err_q;
    logic              range_ok;
    logic              zero_len;
    logic              violation;
    logic              write_fire;
    logic              accept;

    assign accept = (state == S_IDLE) && bus.start;

    dma_range_check u_range_check (
        .src       (cur_src),
        .dst       (cur_dst),
        .len       (remaining),
        .ok        (range_ok),
        .zero_len  (zero_len),
        .violation (violation)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_src   <= '0;
            cur_dst   <= '0;
            remaining <= '0;
            buffer    <= '0;
            err_q     <= 1'b0;
        end else begin
            // err is registered so it lands in the cycle after CHECK, back in IDLE.
            err_q <= (state == S_CHECK) && violation;
            if (accept) begin
                cur_src   <= bus.src_addr;
                cur_dst   <= bus.dst_addr;
                remaining <= bus.len;
            end
            if (state == S_RD_WAIT) begin
                buffer <= bus.mem_rdata;
            end
            if (write_fire) begin
                cur_src   <= cur_src + 1'b1;
                cur_dst   <= cur_dst + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.mem_wr   = 1'b0;
        bus.mem_addr = '0;
        write_fire   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                bus.busy = 1'b1;
                if (zero_len) begin
                    state_next = S_FIN;
                end else if (range_ok) begin
                    state_next = S_RD;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_RD: begin
                bus.busy     = 1'b1;
                bus.mem_addr = cur_src;
                state_next   = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                bus.busy   = 1'b1;
                state_next = S_WR;
            end
            S_WR: begin
                bus.busy     = 1'b1;
                bus.mem_addr = cur_dst;
                // A full memory holds the write off without losing the buffered word.
                if (!bus.mem_full) begin
                    bus.mem_wr = 1'b1;
                    write_fire = 1'b1;
                    state_next = (remaining == ADDR_W'(1)) ? S_FIN : S_RD;
                end
            end
            S_FIN: begin
                bus.done   = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign bus.err       = err_q;
    assign bus.mem_wdata = buffer;

`ifdef DMA_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= '0;
        end else if (write_fire) begin
            csum_q <= csum_q + buffer;
        end
    end

    assign bus.csum = csum_q;
`endif

endmodule

// File: tb/tb_dma_copy_engine.sv
// Scoreboard bench for dma_copy_engine: a transfer-level reference model queues expected
// writes and completions; a negedge monitor checks them as the DUT produces them.
module tb_dma_copy_engine;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    dma_copy_engine_if bus ();

    dma_copy_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        bit          is_done;
        int          latency;
        logic [31:0] csum;
    } cpl_t;

    wr_t         wr_q[$];
    cpl_t        cpl_q[$];
    logic [31:0] mem     [0:191];
    logic [31:0] ref_mem [0:191];

    int errors      = 0;
    int checks      = 0;
    int cyc         = 0;
    int start_cyc   = 0;
    int busy_cnt    = 0;
    int completions = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory with one-clock read latency; read-before-write within a cycle.
    always @(posedge clk) begin
        if (bus.mem_addr < 8'd192) begin
            bus.mem_rdata <= mem[bus.mem_addr];
            if (bus.mem_wr) begin
                mem[bus.mem_addr] = bus.mem_wdata;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT writes or completes.
    always @(negedge clk) begin
        wr_t  w;
        cpl_t c;
        cyc = cyc + 1;
        if (rst_n) begin
            if (bus.start && !bus.busy) begin
                start_cyc = cyc;
                busy_cnt  = 0;
            end
            if (bus.busy) begin
                busy_cnt = busy_cnt + 1;
            end
            if (bus.mem_wr) begin
                if (wr_q.size() == 0) begin
                    checkOutput("unexpected_write", 32'(bus.mem_addr), 32'hFFFF_FFFF);
                end else begin
                    w = wr_q.pop_front();
                    checkOutput("wr_addr", 32'(bus.mem_addr), w.addr);
                    checkOutput("wr_data", bus.mem_wdata, w.data);
                end
            end
            if (bus.done || bus.err) begin
                if (cpl_q.size() == 0) begin
                    checkOutput("unexpected_completion", 32'(bus.done), 32'(bus.err));
                end else begin
                    c = cpl_q.pop_front();
                    checkOutput("cpl_done", 32'(bus.done), 32'(c.is_done));
                    checkOutput("cpl_err", 32'(bus.err), 32'(!c.is_done));
                    checkOutput("cpl_latency", cyc - start_cyc, c.latency);
                    checkOutput("busy_cycles", busy_cnt, c.latency - 1);
`ifdef DMA_CHECKSUM_EN
                    checkOutput("csum", bus.csum, c.csum);
`endif
                end
                completions = completions + 1;
            end
        end
    end

    task automatic preload(input int addr, input logic [31:0] data);
        mem[addr]     = data;
        ref_mem[addr] = data;
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_busy", 32'(bus.busy), 0);
        checkOutput("rst_done", 32'(bus.done), 0);
        checkOutput("rst_err", 32'(bus.err), 0);
        checkOutput("rst_mem_wr", 32'(bus.mem_wr), 0);
        checkOutput("rst_mem_addr", 32'(bus.mem_addr), 0);
        checkOutput("rst_mem_wdata", bus.mem_wdata, 0);
`ifdef DMA_CHECKSUM_EN
        checkOutput("rst_csum", bus.csum, 0);
`endif
    endtask

    // Transfer-level reference: ascending word copy, range rules, 2 + 3*len + stall cycles.
    task automatic applyStimulus(input int src, input int dst, input int len, input int stall);
        cpl_t        c;
        wr_t         w;
        logic [31:0] sum;
        bit          valid;
        int          base;
        int          budget;
        valid = 1'b0;
        sum   = '0;
        base  = completions;
        if (len == 0) begin
            c = '{is_done: 1'b1, latency: 2, csum: 32'd0};
        end else if (src + len > 192 || dst + len > 191) begin
            c = '{is_done: 1'b0, latency: 2, csum: 32'd0};
        end else begin
            valid = 1'b1;
            for (int i = 0; i < len; i++) begin
                w.addr = dst + i;
                w.data = ref_mem[src + i];
                ref_mem[dst + i] = w.data;
                sum = sum + w.data;
                wr_q.push_back(w);
            end
            c = '{is_done: 1'b1, latency: 2 + 3 * len + stall, csum: sum};
        end
        cpl_q.push_back(c);

        bus.src_addr = 8'(src);
        bus.dst_addr = 8'(dst);
        bus.len      = 8'(len);
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.src_addr = 8'($urandom);
        bus.dst_addr = 8'($urandom);
        bus.len      = 8'($urandom);
        if (valid && stall > 0) begin
            repeat (3) @(posedge clk);
            #1;
            bus.mem_full = 1'b1;
            repeat (stall) @(posedge clk);
            #1;
            bus.mem_full = 1'b0;
        end
        budget = 3 * len + stall + 20;
        for (int k = 0; k < budget && completions == base; k++) begin
            @(posedge clk);
        end
        #1;
        if (completions == base) begin
            checkOutput("completion_timeout", 0, 1);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int s;
        int d;
        int l;
        bus.start    = 1'b0;
        bus.src_addr = '0;
        bus.dst_addr = '0;
        bus.len      = '0;
        bus.mem_full = 1'b0;
        for (int i = 0; i < 192; i++) begin
            preload(i, $urandom);
        end
        #2;
        checkResetOutputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] basic copy, len=3");
        preload(0, 32'd8);
        preload(1, 32'd9);
        preload(2, 32'd12);
        applyStimulus(0, 10, 3, 0);

        $display("[TB] zero length, dst overflow, src overflow, boundary fits");
        applyStimulus(5, 20, 0, 0);
        applyStimulus(0, 189, 3, 0);
        applyStimulus(190, 0, 3, 0);
        applyStimulus(189, 188, 3, 0);

        $display("[TB] mem_full stall and overlapping ranges");
        applyStimulus(20, 30, 2, 4);
        applyStimulus(60, 62, 5, 0);

        $display("[TB] checksum wrap-around data");
        preload(40, 32'hFFFF_FFFF);
        preload(41, 32'd2);
        applyStimulus(40, 50, 2, 0);

        $display("[TB] reset after first of four words");
        begin
            wr_t w;
            w.addr = 80;
            w.data = ref_mem[70];
            ref_mem[80] = w.data;
            wr_q.push_back(w);
        end
        bus.src_addr = 8'd70;
        bus.dst_addr = 8'd80;
        bus.len      = 8'd4;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkResetOutputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(70, 80, 4, 0);

        $display("[TB] randomized transfers");
        for (int n = 0; n < 12; n++) begin
            s = $urandom_range(0, 195);
            d = $urandom_range(0, 195);
            l = $urandom_range(0, 8);
            applyStimulus(s, d, l, $urandom_range(0, 3));
        end

        checkOutput("wr_queue_drained", wr_q.size(), 0);
        checkOutput("cpl_queue_drained", cpl_q.size(), 0);
        for (int i = 0; i < 192; i++) begin
            checkOutput($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
